// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller with halt drain FSM
// and free-running performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [2:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic exc_m;
  logic exc_w;
  logic run_en;

  assign load_use = ((E_icode == I_MRMOVQ) ||
                     (E_icode == I_POPQ)) &&
                    (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) ||
                     (E_dstM == d_srcB));

  assign ret_pend = (D_icode == I_RET) ||
                    (E_icode == I_RET) ||
                    (M_icode == I_RET);

  assign mispred = (E_icode == I_JXX) && !e_Cnd;

  assign exc_m = (m_stat == S_HLT) ||
                 (m_stat == S_ADR) ||
                 (m_stat == S_INS);

  assign exc_w = (W_stat == S_HLT) ||
                 (W_stat == S_ADR) ||
                 (W_stat == S_INS);

  assign run_en = (state != STOP);

  always_comb begin
    state_nx = state;
    F_stall  = load_use || ret_pend;
    D_stall  = load_use;
    // a mispredict squashes decode even under load-use
    D_bubble = mispred || (ret_pend && !load_use);
    E_bubble = mispred || load_use;
    M_bubble = exc_m || exc_w;
    W_stall  = exc_w;
    set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
    unique case (state)
      RUN: begin
        if (exc_w)
          state_nx = STOP;
        else if (exc_m)
          state_nx = DRAIN;
      end
      DRAIN: begin
        set_cc = 1'b0;
        if (exc_w)
          state_nx = STOP;
      end
      STOP: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= RUN;
      halted    <= 1'b0;
      proc_stat <= S_AOK;
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      if (run_en && state_nx == STOP) begin
        halted    <= 1'b1;
        proc_stat <= W_stat;
      end
      if (run_en) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (F_stall)
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (mispred)
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl
// (main instance plus a 4-bit counter instance for wrap).
module tb_pipe_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  D_icode, d_srcA, d_srcB;
  logic [3:0]  E_icode, E_dstM, M_icode;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble;
  logic        E_bubble, M_bubble, W_stall, set_cc;
  logic [2:0]  proc_stat;
  logic        halted;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

  logic        w_F_stall, w_D_stall, w_D_bubble;
  logic        w_E_bubble, w_M_bubble, w_W_stall, w_set_cc;
  logic [2:0]  w_proc_stat;
  logic        w_halted;
  logic [3:0]  w_cyc, w_stall, w_flush;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble,
                M_bubble, W_stall, set_cc};

  pipe_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .proc_stat(proc_stat),
    .halted(halted), .cyc_cnt(cyc_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut_w (
    .CLK(CLK), .RST_N(RST_N),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(w_F_stall), .D_stall(w_D_stall),
    .D_bubble(w_D_bubble), .E_bubble(w_E_bubble),
    .M_bubble(w_M_bubble), .W_stall(w_W_stall),
    .set_cc(w_set_cc), .proc_stat(w_proc_stat),
    .halted(w_halted), .cyc_cnt(w_cyc),
    .stall_cnt(w_stall), .flush_cnt(w_flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    D_icode = 4'h1;
    d_srcA  = 4'hF;
    d_srcB  = 4'hF;
    E_icode = 4'h1;
    E_dstM  = 4'hF;
    e_Cnd   = 1'b1;
    M_icode = 4'h1;
    m_stat  = 3'd1;
    W_stat  = 3'd1;
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    step();
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stat", 32'(proc_stat), 32'd1);
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);

    // outputs stay live during reset
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("rst_comb_lu", 32'(ctl), 32'b1101000);
    step();
    chk("rst_cyc_hold", cyc_cnt, 32'd0);
    chk("rst_stall_hold", stall_cnt, 32'd0);

    RST_N = 1'b1;
    idle();
    #1;
    chk("idle_ctl", 32'(ctl), 32'd0);
    step();
    chk("cyc1", cyc_cnt, 32'd1);

    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_ctl", 32'(ctl), 32'b1101000);
    step();
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    idle();
    E_icode = 4'hB; E_dstM = 4'h2; d_srcB = 4'h2;
    #1;
    chk("lu_pop_ctl", 32'(ctl), 32'b1101000);
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    #1;
    chk("lu_none_ctl", 32'(ctl), 32'd0);
    step();

    idle();
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    chk("mp_ctl", 32'(ctl), 32'b0011000);
    step();
    chk("mp_flush_cnt", flush_cnt, 32'd1);
    chk("mp_stall_cnt", stall_cnt, 32'd1);

    e_Cnd = 1'b1;
    #1;
    chk("jmp_taken_ctl", 32'(ctl), 32'd0);
    step();

    idle();
    D_icode = 4'h9;
    #1;
    chk("ret_d_ctl", 32'(ctl), 32'b1010000);
    step();
    D_icode = 4'h1; E_icode = 4'h9;
    #1;
    chk("ret_e_ctl", 32'(ctl), 32'b1010000);
    step();
    E_icode = 4'h1; M_icode = 4'h9;
    #1;
    chk("ret_m_ctl", 32'(ctl), 32'b1010000);
    step();
    chk("ret_stall_cnt", stall_cnt, 32'd4);
    M_icode = 4'h1; E_icode = 4'h6;
    #1;
    chk("opq_ctl", 32'(ctl), 32'b0000001);
    step();
    chk("cyc9", cyc_cnt, 32'd9);

    m_stat = 3'd2;
    #1;
    chk("hlt_m_ctl", 32'(ctl), 32'b0000100);
    step();
    chk("drain_halted", 32'(halted), 32'd0);
    chk("drain_stat", 32'(proc_stat), 32'd1);

    m_stat = 3'd1;
    #1;
    chk("drain_setcc", 32'(ctl), 32'd0);
    step();

    W_stat = 3'd2;
    #1;
    chk("hlt_w_ctl", 32'(ctl), 32'b0000110);
    step();
    chk("stop_halted", 32'(halted), 32'd1);
    chk("stop_stat", 32'(proc_stat), 32'd2);
    chk("stop_cyc", cyc_cnt, 32'd12);

    idle();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    #1;
    chk("stop_ctl", 32'(ctl), 32'b1100110);
    step();
    step();
    chk("stop_cyc_frz", cyc_cnt, 32'd12);
    chk("stop_stall_frz", stall_cnt, 32'd4);
    chk("stop_flush_frz", flush_cnt, 32'd1);
    chk("stop_halted_hold", 32'(halted), 32'd1);
    chk("stop_stat_hold", 32'(proc_stat), 32'd2);

    idle();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
    chk("rs_halted", 32'(halted), 32'd0);
    chk("rs_stat", 32'(proc_stat), 32'd1);
    chk("rs_cyc", cyc_cnt, 32'd0);
    chk("rs_stall", stall_cnt, 32'd0);
    chk("rs_flush", flush_cnt, 32'd0);
    chk("rs_ctl", 32'(ctl), 32'd0);
    chk("w_rs_cyc", 32'(w_cyc), 32'd0);

    for (int i = 0; i < 15; i++) step();
    chk("w_cyc15", 32'(w_cyc), 32'd15);
    step();
    chk("w_cyc_wrap", 32'(w_cyc), 32'd0);
    chk("cyc16", cyc_cnt, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
